// File: rtl/m_dram_app_model.sv
// rtl/m_dram_app_model.sv - cycle-level model of a DDR3 controller native user (app_*) interface
//
// Services one command at a time against a 128-bit line array, so a simulation top can
// run without vendor memory IP. The array is zeroed at time zero only; reset does not
// clear it.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   o_init_calib_complete     high once the post-reset calibration delay has elapsed
//   i_app_en/i_app_cmd/i_app_addr, o_app_rdy
//                             command handshake (000 write, 001 read, others dropped)
//   i_app_wdf_wren/i_app_wdf_data/i_app_wdf_mask/i_app_wdf_end, o_app_wdf_rdy
//                             write-data handshake into a one-entry buffer (mask 1 = keep byte)
//   o_app_rd_data, o_app_rd_data_valid, o_app_rd_data_end
//                             one-cycle read return, READ_LATENCY cycles after accept
//
// Optional feature macro: DRAM_MODEL_BACKPRESSURE_EN
//   When defined, a 16-bit LFSR (seed 16'hACE1) randomly withholds o_app_rdy in IDLE
//   (lfsr[0]) and o_app_wdf_rdy (lfsr[1]) to exercise upstream stall handling.
module m_dram_app_model #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_CMD_WIDTH  = 3,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int LINE_BITS      = 10,
    parameter int READ_LATENCY   = 8,
    parameter int CALIB_CYCLES   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    output logic                      o_init_calib_complete,
    input  logic                      i_app_en,
    input  logic [APP_CMD_WIDTH-1:0]  i_app_cmd,
    input  logic [APP_ADDR_WIDTH-1:0] i_app_addr,
    output logic                      o_app_rdy,
    input  logic                      i_app_wdf_wren,
    input  logic [APP_DATA_WIDTH-1:0] i_app_wdf_data,
    input  logic [APP_MASK_WIDTH-1:0] i_app_wdf_mask,
    input  logic                      i_app_wdf_end,
    output logic                      o_app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0] o_app_rd_data,
    output logic                      o_app_rd_data_valid,
    output logic                      o_app_rd_data_end
);

    localparam int LINES = 1 << LINE_BITS;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);

    localparam logic [1:0] ST_CALIB = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WR    = 2'd2;
    localparam logic [1:0] ST_RD    = 2'd3;

    localparam logic [APP_CMD_WIDTH-1:0] CMD_WRITE = APP_CMD_WIDTH'(0);
    localparam logic [APP_CMD_WIDTH-1:0] CMD_READ  = APP_CMD_WIDTH'(1);

    logic [1:0]                state;
    logic [CAL_W-1:0]          calib_cnt;
    logic                      calib_done;
    logic [LAT_W-1:0]          lat_cnt;
    logic [LINE_BITS-1:0]      wr_line;
    logic [LINE_BITS-1:0]      rd_line;
    logic                      buf_full;
    logic [APP_DATA_WIDTH-1:0] buf_data;
    logic [APP_MASK_WIDTH-1:0] buf_mask;

    logic [APP_DATA_WIDTH-1:0] mem [LINES] = '{default: '0};

    logic                      stall_cmd;
    logic                      stall_wdf;
    logic                      cmd_acc;
    logic                      wdf_acc;
    logic                      commit;
    logic                      rd_done;
    logic [LINE_BITS-1:0]      addr_line;
    logic [APP_DATA_WIDTH-1:0] commit_data;
    logic [APP_MASK_WIDTH-1:0] commit_mask;

`ifdef DRAM_MODEL_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // Fibonacci form of x^16+x^14+x^13+x^11+1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall_cmd = ~lfsr[0];
    assign stall_wdf = ~lfsr[1];
`else
    assign stall_cmd = 1'b0;
    assign stall_wdf = 1'b0;
`endif

    // Word address -> line index; low 3 bits select a word inside the line and upper
    // bits alias onto the stored lines.
    assign addr_line = i_app_addr[LINE_BITS+2:3];

    assign o_app_rdy     = (state == ST_IDLE) && !stall_cmd;
    // In WR with a full buffer the commit happens on this edge, so a new beat can be
    // taken into the slot being vacated.
    assign o_app_wdf_rdy = (state != ST_CALIB) && (!buf_full || state == ST_WR) && !stall_wdf;

    assign cmd_acc = i_app_en && o_app_rdy;
    assign wdf_acc = i_app_wdf_wren && o_app_wdf_rdy;

    // A write commits as soon as its data is present, either buffered or arriving now.
    assign commit      = (state == ST_WR) && (buf_full || wdf_acc);
    assign commit_data = buf_full ? buf_data : i_app_wdf_data;
    assign commit_mask = buf_full ? buf_mask : i_app_wdf_mask;

    // lat_cnt is 0 in the first cycle after accept, so the strobe lands READ_LATENCY
    // cycles after the accepting edge; RD is left only after the strobe cycle.
    assign rd_done = (state == ST_RD) && (lat_cnt == LAT_W'(READ_LATENCY - 1));

    assign o_init_calib_complete = calib_done;
    assign o_app_rd_data_valid   = rd_done;
    assign o_app_rd_data_end     = rd_done;
    assign o_app_rd_data         = rd_done ? mem[rd_line] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_CALIB;
            calib_cnt  <= '0;
            calib_done <= 1'b0;
            lat_cnt    <= '0;
            wr_line    <= '0;
            rd_line    <= '0;
            buf_full   <= 1'b0;
        end else begin
            case (state)
                ST_CALIB: begin
                    if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
                        state      <= ST_IDLE;
                        calib_done <= 1'b1;
                    end else begin
                        calib_cnt <= calib_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cmd_acc) begin
                        if (i_app_cmd == CMD_WRITE) begin
                            state   <= ST_WR;
                            wr_line <= addr_line;
                        end else if (i_app_cmd == CMD_READ) begin
                            state   <= ST_RD;
                            rd_line <= addr_line;
                            lat_cnt <= '0;
                        end
                    end
                end
                ST_WR: begin
                    if (commit) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (rd_done) begin
                        state <= ST_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= ST_CALIB;
            endcase

            // A commit from an empty buffer consumes the incoming beat directly; from a
            // full buffer it may be refilled by a beat accepted on the same edge.
            if (commit) begin
                buf_full <= buf_full && wdf_acc;
            end else if (wdf_acc) begin
                buf_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wdf_acc) begin
            buf_data <= i_app_wdf_data;
            buf_mask <= i_app_wdf_mask;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && commit) begin
            for (int b = 0; b < APP_MASK_WIDTH; b++) begin
                if (!commit_mask[b]) begin
                    mem[wr_line][b*8 +: 8] <= commit_data[b*8 +: 8];
                end
            end
        end
    end

    // Lines are single-beat, so every accepted write-data beat must be the last one.
    assert property (@(posedge i_clk) disable iff (i_rst)
        (i_app_wdf_wren && o_app_wdf_rdy) |-> i_app_wdf_end);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_app_addr[APP_ADDR_WIDTH-1:LINE_BITS+3], i_app_addr[2:0],
                                i_app_wdf_end};

endmodule

// File: tb/tb_m_dram_app_model.sv
// tb/tb_m_dram_app_model.sv - randomized self-checking bench for m_dram_app_model
module tb_m_dram_app_model;

    localparam int LINE_BITS    = 10;
    localparam int READ_LATENCY = 8;
    localparam int CALIB_CYCLES = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         app_en = 1'b0;
    logic [2:0]   app_cmd = '0;
    logic [27:0]  app_addr = '0;
    logic         app_wdf_wren = 1'b0;
    logic [127:0] app_wdf_data = '0;
    logic [15:0]  app_wdf_mask = '0;
    logic         app_wdf_end = 1'b1;
    logic         o_init_calib_complete;
    logic         o_app_rdy;
    logic         o_app_wdf_rdy;
    logic [127:0] o_app_rd_data;
    logic         o_app_rd_data_valid;
    logic         o_app_rd_data_end;

    int tests_run = 0;
    int tests_failed = 0;

    logic [127:0] model [1 << LINE_BITS];

    localparam logic [127:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

    m_dram_app_model #(
        .APP_ADDR_WIDTH(28), .APP_CMD_WIDTH(3), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16),
        .LINE_BITS(LINE_BITS), .READ_LATENCY(READ_LATENCY), .CALIB_CYCLES(CALIB_CYCLES)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .o_init_calib_complete(o_init_calib_complete),
        .i_app_en(app_en),
        .i_app_cmd(app_cmd),
        .i_app_addr(app_addr),
        .o_app_rdy(o_app_rdy),
        .i_app_wdf_wren(app_wdf_wren),
        .i_app_wdf_data(app_wdf_data),
        .i_app_wdf_mask(app_wdf_mask),
        .i_app_wdf_end(app_wdf_end),
        .o_app_wdf_rdy(o_app_wdf_rdy),
        .o_app_rd_data(o_app_rd_data),
        .o_app_rd_data_valid(o_app_rd_data_valid),
        .o_app_rd_data_end(o_app_rd_data_end)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic int line_of(input logic [27:0] a);
        return int'(a[LINE_BITS+2:3]);
    endfunction

    function automatic void model_write(input logic [27:0] a, input logic [127:0] d,
                                        input logic [15:0] m);
        for (int b = 0; b < 16; b++) begin
            if (!m[b]) model[line_of(a)][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // All drivers below start and end on a falling edge.
    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1; app_en = 1'b0; app_wdf_wren = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_calib(output int edges);
        edges = -1;
        for (int k = 1; k <= CALIB_CYCLES + 8 && edges < 0; k++) begin
            @(negedge clk);
            if (o_init_calib_complete) edges = k;
        end
    endtask

    task automatic drive_write(input logic [27:0] a, input logic [127:0] d,
                               input logic [15:0] m, output bit ok);
        bit cdone = 0;
        bit ddone = 0;
        app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
        app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1;
        for (int i = 0; i < 50 && !(cdone && ddone); i++) begin
            if (app_en && o_app_rdy) cdone = 1;
            if (app_wdf_wren && o_app_wdf_rdy) ddone = 1;
            @(negedge clk);
            if (cdone) app_en = 1'b0;
            if (ddone) app_wdf_wren = 1'b0;
        end
        app_en = 1'b0; app_wdf_wren = 1'b0;
        ok = cdone && ddone;
        for (int i = 0; i < 50 && !o_app_rdy; i++) @(negedge clk);
        ok = ok && o_app_rdy;
    endtask

    task automatic do_read(input logic [27:0] a, output logic [127:0] d, output int lat,
                           output int nvalid, output int end_bad, output bit ok);
        bit acc = 0;
        d = '0; lat = -1; nvalid = 0; end_bad = 0;
        app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (o_app_rdy) acc = 1;
            @(negedge clk);
        end
        app_en = 1'b0;
        ok = acc;
        for (int k = 1; k <= READ_LATENCY + 10; k++) begin
            if (o_app_rd_data_valid) begin
                if (lat < 0) begin
                    lat = k;
                    d = o_app_rd_data;
                end
                nvalid++;
            end
            if (o_app_rd_data_end !== o_app_rd_data_valid) end_bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int rise = -1;
        int early = 0;
        apply_reset(3);
        tests_run++;
        if ({o_init_calib_complete, o_app_rdy, o_app_wdf_rdy, o_app_rd_data_valid,
             o_app_rd_data_end} !== 5'b0 || o_app_rd_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got calib=%b rdy=%b wdf_rdy=%b valid=%b end=%b data=%h, expected all 0",
                     o_init_calib_complete, o_app_rdy, o_app_wdf_rdy, o_app_rd_data_valid,
                     o_app_rd_data_end, o_app_rd_data);
        end
        for (int k = 1; k <= CALIB_CYCLES + 4; k++) begin
            @(negedge clk);
            if (o_init_calib_complete && rise < 0) rise = k;
            if (rise < 0 && (o_app_rdy || o_app_wdf_rdy)) early++;
        end
        tests_run++;
        if (rise !== CALIB_CYCLES) begin
            tests_failed++;
            $display("FAIL calib_rise: got %0d edges, expected %0d", rise, CALIB_CYCLES);
        end
        tests_run++;
        if (early !== 0) begin
            tests_failed++;
            $display("FAIL rdy_during_calib: got %0d ready cycles, expected 0", early);
        end
        tests_run++;
        if (o_app_rdy !== 1'b1 || o_app_wdf_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rdy_after_calib: got rdy=%b wdf_rdy=%b, expected 1 1", o_app_rdy, o_app_wdf_rdy);
        end
    endtask

    task automatic test_write_read();
        bit ok;
        logic [127:0] d;
        int lat, nv, eb;
        drive_write(28'h40, PAT, 16'h0, ok);
        model_write(28'h40, PAT, 16'h0);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_handshake: got ok=%b, expected 1", ok);
        end
        do_read(28'h40, d, lat, nv, eb, ok);
        tests_run++;
        if (d !== PAT) begin
            tests_failed++;
            $display("FAIL rd_data_0x40: got %h, expected %h", d, PAT);
        end
        tests_run++;
        if (lat !== READ_LATENCY) begin
            tests_failed++;
            $display("FAIL rd_latency: got %0d, expected %0d", lat, READ_LATENCY);
        end
        tests_run++;
        if (nv !== 1 || eb !== 0 || ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_strobe: got valid_cycles=%0d end_mismatch=%0d ok=%b, expected 1 0 1", nv, eb, ok);
        end
    endtask

    task automatic test_data_first();
        logic [127:0] w = rand128();
        logic [127:0] d;
        int lat, nv, eb;
        int rdy_bad = 0;
        bit beat_ok, cmd_ok, ok;
        app_wdf_wren = 1'b1; app_wdf_data = w; app_wdf_mask = 16'h0; app_wdf_end = 1'b1;
        beat_ok = o_app_wdf_rdy;
        @(negedge clk);
        app_wdf_wren = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (o_app_wdf_rdy !== 1'b0) rdy_bad++;
            if (k == 5) begin
                app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h48;
            end else begin
                @(negedge clk);
            end
        end
        cmd_ok = o_app_rdy;
        @(negedge clk);
        app_en = 1'b0;
        @(negedge clk);
        model_write(28'h48, w, 16'h0);
        tests_run++;
        if (rdy_bad !== 0 || beat_ok !== 1'b1 || cmd_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL data_first_rdy: got wdf_rdy_high=%0d beat_ok=%b cmd_ok=%b, expected 0 1 1",
                     rdy_bad, beat_ok, cmd_ok);
        end
        tests_run++;
        if (o_app_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL data_first_idle: got rdy=%b two cycles after cmd, expected 1", o_app_rdy);
        end
        do_read(28'h48, d, lat, nv, eb, ok);
        tests_run++;
        if (d !== w) begin
            tests_failed++;
            $display("FAIL data_first_read: got %h, expected %h", d, w);
        end
    endtask

    task automatic test_masked();
        logic [127:0] d;
        int lat, nv, eb;
        bit ok;
        drive_write(28'h80, {128{1'b1}}, 16'hFFF0, ok);
        model_write(28'h80, {128{1'b1}}, 16'hFFF0);
        do_read(28'h80, d, lat, nv, eb, ok);
        tests_run++;
        if (d !== 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF) begin
            tests_failed++;
            $display("FAIL masked_write: got %h, expected %h", d,
                     128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
        end
    endtask

    task automatic test_alias();
        logic [127:0] w1 = rand128();
        logic [127:0] w2 = rand128();
        logic [127:0] d;
        int lat, nv, eb;
        bit ok;
        drive_write(28'h0, w1, 16'h0, ok);
        model_write(28'h0, w1, 16'h0);
        do_read(28'h1 << (LINE_BITS + 3), d, lat, nv, eb, ok);
        tests_run++;
        if (d !== w1) begin
            tests_failed++;
            $display("FAIL alias_high_bits: got %h, expected %h", d, w1);
        end
        drive_write((28'h5 << (LINE_BITS + 3)) | 28'h18, w2, 16'h0, ok);
        model_write((28'h5 << (LINE_BITS + 3)) | 28'h18, w2, 16'h0);
        do_read(28'h1F, d, lat, nv, eb, ok);
        tests_run++;
        if (d !== model[3] || d !== w2) begin
            tests_failed++;
            $display("FAIL alias_low_bits: got %h, expected %h", d, w2);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int ndata = 0;
        logic [127:0] w1 = rand128();
        logic [127:0] w2 = rand128();
        logic [127:0] d;
        int lat, nv, eb;
        bit ok;
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h40;
        for (int k = 0; k < 40 && second < 0; k++) begin
            if (o_app_rdy) begin
                if (first < 0) first = k;
                else second = k;
            end
            @(negedge clk);
        end
        app_en = 1'b0;
        tests_run++;
        if (second - first !== READ_LATENCY + 1) begin
            tests_failed++;
            $display("FAIL read_turnaround: got %0d cycles, expected %0d", second - first, READ_LATENCY + 1);
        end
        repeat (READ_LATENCY + 4) @(negedge clk);

        first = -1; second = -1;
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h200;
        app_wdf_wren = 1'b1; app_wdf_data = w1; app_wdf_mask = 16'h0;
        for (int k = 0; k < 40 && !(second >= 0 && ndata == 2); k++) begin
            bit dacc, cacc;
            dacc = app_wdf_wren && o_app_wdf_rdy;
            cacc = app_en && o_app_rdy;
            if (cacc) begin
                if (first < 0) first = k;
                else second = k;
            end
            @(negedge clk);
            if (dacc) begin
                ndata++;
                if (ndata == 1) app_wdf_data = w2;
                else app_wdf_wren = 1'b0;
            end
            if (cacc) begin
                if (second < 0) app_addr = 28'h208;
                else app_en = 1'b0;
            end
        end
        app_en = 1'b0; app_wdf_wren = 1'b0;
        for (int i = 0; i < 20 && !o_app_rdy; i++) @(negedge clk);
        model_write(28'h200, w1, 16'h0);
        model_write(28'h208, w2, 16'h0);
        tests_run++;
        if (second - first !== 2) begin
            tests_failed++;
            $display("FAIL write_turnaround: got %0d cycles, expected 2", second - first);
        end
        do_read(28'h200, d, lat, nv, eb, ok);
        tests_run++;
        if (d !== w1) begin
            tests_failed++;
            $display("FAIL b2b_write_first: got %h, expected %h", d, w1);
        end
        do_read(28'h208, d, lat, nv, eb, ok);
        tests_run++;
        if (d !== w2) begin
            tests_failed++;
            $display("FAIL b2b_write_second: got %h, expected %h", d, w2);
        end
    endtask

    task automatic test_reset_mid_read();
        int nvalid = 0;
        int rise = -1;
        logic [127:0] d;
        int lat, nv, eb;
        bit ok;
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h40;
        for (int i = 0; i < 50 && !o_app_rdy; i++) @(negedge clk);
        @(negedge clk);
        app_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (o_app_rd_data_valid) nvalid++;
            @(negedge clk);
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (o_app_rd_data_valid) nvalid++;
        end
        rst = 1'b0;
        for (int k = 1; k <= CALIB_CYCLES + READ_LATENCY; k++) begin
            @(negedge clk);
            if (o_app_rd_data_valid) nvalid++;
            if (o_init_calib_complete && rise < 0) rise = k;
        end
        tests_run++;
        if (nvalid !== 0) begin
            tests_failed++;
            $display("FAIL reset_drops_read: got %0d valid strobes, expected 0", nvalid);
        end
        tests_run++;
        if (rise !== CALIB_CYCLES) begin
            tests_failed++;
            $display("FAIL recalib_rise: got %0d edges, expected %0d", rise, CALIB_CYCLES);
        end
        do_read(28'h40, d, lat, nv, eb, ok);
        tests_run++;
        if (d !== model[line_of(28'h40)]) begin
            tests_failed++;
            $display("FAIL mem_survives_reset: got %h, expected %h", d, model[line_of(28'h40)]);
        end
    endtask

    task automatic test_random();
        int rd_bad = 0;
        int lat_bad = 0;
        int strobe_bad = 0;
        int nop_bad = 0;
        for (int n = 0; n < 40; n++) begin
            int op = $urandom_range(0, 9);
            logic [27:0] a = 28'($urandom);
            logic [127:0] w = rand128();
            logic [15:0] m = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
            logic [127:0] d;
            int lat, nv, eb;
            bit ok;
            a[LINE_BITS+2:3] = 10'(512 + $urandom_range(0, 15));
            if (op <= 4) begin
                drive_write(a, w, m, ok);
                model_write(a, w, m);
                if (!ok) strobe_bad++;
            end else if (op <= 8) begin
                do_read(a, d, lat, nv, eb, ok);
                if (d !== model[line_of(a)]) begin
                    rd_bad++;
                    $display("FAIL random_read line %0d: got %h, expected %h", line_of(a), d, model[line_of(a)]);
                end
                if (lat !== READ_LATENCY) lat_bad++;
                if (nv !== 1 || eb !== 0 || !ok) strobe_bad++;
            end else begin
                app_en = 1'b1; app_cmd = 3'($urandom_range(2, 7)); app_addr = a;
                for (int i = 0; i < 50 && !o_app_rdy; i++) @(negedge clk);
                @(negedge clk);
                app_en = 1'b0;
                if (o_app_rdy !== 1'b1 || o_app_rd_data_valid !== 1'b0) nop_bad++;
            end
        end
        tests_run++;
        if (rd_bad !== 0) begin
            tests_failed++;
            $display("FAIL random_data: got %0d bad reads, expected 0", rd_bad);
        end
        tests_run++;
        if (lat_bad !== 0 || strobe_bad !== 0) begin
            tests_failed++;
            $display("FAIL random_timing: got %0d latency and %0d handshake errors, expected 0 0", lat_bad, strobe_bad);
        end
        tests_run++;
        if (nop_bad !== 0) begin
            tests_failed++;
            $display("FAIL unknown_cmd: got %0d non-idle after unknown command, expected 0", nop_bad);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << LINE_BITS); i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_data_first();
        test_masked();
        test_alias();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
